// File: rtl/cache_line_filler.sv
// cache_line_filler: miss-service engine for a direct-mapped L1 data cache.
// On a miss it fetches a full line word by word from main memory using a
// valid/ack handshake. It assembles the words into a BLOCK_SIZE-bit line and
// then pulses o_cache_read low for one cycle so the cache writes the line.
//
// Optional feature, enabled by defining CACHE_FILL_CRITICAL_FIRST_EN:
// critical-word-first fetch order, with o_crit_valid / o_crit_word outputs.
//
// Handshake: o_mem_rd is the request valid and i_mem_ack is the ready. A
// word transfers in every cycle where both are high, and i_mem_rdata is
// valid in that same cycle. While o_mem_rd is high and i_mem_ack is low,
// o_mem_addr is held. i_mem_ack is ignored when o_mem_rd is low.
module cache_line_filler #(
    parameter int WORDS      = 16,
    parameter int SIZE       = 32,
    parameter int BLOCK_SIZE = 512
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_miss,
    input  logic [SIZE-1:0]       i_cpu_addr,
    output logic                  o_mem_rd,
    output logic [SIZE-1:0]       o_mem_addr,
    input  logic [SIZE-1:0]       i_mem_rdata,
    input  logic                  i_mem_ack,
    output logic                  o_cache_read,
    output logic [SIZE-1:0]       o_cache_addr,
    output logic [BLOCK_SIZE-1:0] o_block_data,
    output logic                  o_busy,
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
    output logic                  o_crit_valid,
    output logic [SIZE-1:0]       o_crit_word,
`endif
    output logic [1:0]            o_dbg_state
);

    localparam int IDX_W = $clog2(WORDS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_FILL    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_mem_rd;
    logic [SIZE-1:0]       r_mem_addr;
    logic                  r_cache_read;
    logic [BLOCK_SIZE-1:0] r_block;
    logic                  r_busy;
    logic [SIZE-1:0]       r_cap_addr;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      r_cnt;

    logic [IDX_W-1:0]      w_start_idx;
    logic [IDX_W-1:0]      w_idx_next;
    logic                  w_ack;
    logic                  w_last;

`ifdef CACHE_FILL_CRITICAL_FIRST_EN
    logic [SIZE-1:0]       r_crit_word;
    logic                  w_crit_hit;
    assign w_start_idx = i_cpu_addr[IDX_W-1:0];
`else
    assign w_start_idx = '0;
`endif

    // The request is high for the whole of REQ, so an ack only counts in REQ.
    assign w_ack      = (r_state == S_REQ) && i_mem_ack;
    assign w_idx_next = r_idx + 1'b1;
    // Completion is decided by the number of accepted words. The word index
    // wraps, so it cannot tell when the line is complete.
    assign w_last     = w_ack && (r_cnt == IDX_W'(WORDS - 1));

    // Fill sequencer: capture the miss, fetch the words, pulse the cache write, release.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_mem_rd     <= 1'b0;
            r_mem_addr   <= '0;
            r_cache_read <= 1'b1;
            r_block      <= '0;
            r_busy       <= 1'b0;
            r_cap_addr   <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
            r_crit_word  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_miss) begin
                        r_cap_addr <= i_cpu_addr;
                        r_idx      <= w_start_idx;
                        r_cnt      <= '0;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= {i_cpu_addr[SIZE-1:IDX_W], w_start_idx};
                        r_busy     <= 1'b1;
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
                        r_crit_word <= '0;
`endif
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (w_ack) begin
                        r_block[r_idx*SIZE +: SIZE] <= i_mem_rdata;
                        r_idx      <= w_idx_next;
                        r_cnt      <= r_cnt + 1'b1;
                        r_mem_addr <= {r_cap_addr[SIZE-1:IDX_W], w_idx_next};
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
                        if (r_cnt == '0) begin
                            r_crit_word <= i_mem_rdata;
                        end
`endif
                        if (w_last) begin
                            r_mem_rd     <= 1'b0;
                            r_cache_read <= 1'b0;
                            r_state      <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    r_cache_read <= 1'b1;
                    r_state      <= S_RELEASE;
                end
                S_RELEASE: begin
                    // Any miss seen here comes from the cache's stale lookup and is dropped.
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CACHE_FILL_CRITICAL_FIRST_EN
    // The requested word is always the first one fetched. It is forwarded in the cycle it arrives.
    assign w_crit_hit   = w_ack && (r_cnt == '0);
    assign o_crit_valid = w_crit_hit;
    assign o_crit_word  = w_crit_hit ? i_mem_rdata : r_crit_word;
`endif

    assign o_mem_rd     = r_mem_rd;
    assign o_mem_addr   = r_mem_addr;
    assign o_cache_read = r_cache_read;
    assign o_cache_addr = r_busy ? r_cap_addr : i_cpu_addr;
    assign o_block_data = r_block;
    assign o_busy       = r_busy;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_cache_line_filler.sv
// Bench for cache_line_filler: directed misses against a memory model whose
// read data is mem_addr XOR salt. The expected word addresses, lines and
// capture addresses are queued when each miss is issued. A negedge monitor
// pops the queues and compares them as the handshakes and fills happen.
module tb_cache_line_filler;

    logic         clk = 1'b0;
    logic         reset;
    logic         miss;
    logic [31:0]  cpu_addr;
    logic         mem_rd;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_rdata;
    logic         mem_ack;
    logic         cache_read;
    logic [31:0]  cache_addr;
    logic [511:0] block_data;
    logic         busy;
    logic [1:0]   dbg_state;
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
    logic         crit_valid;
    logic [31:0]  crit_word;
`endif

    int           cyc = 0;
    logic [1:0]   ack_mode;   // 0: ack tied high, 1: ack on odd cycles, 2: ack off
    logic [31:0]  salt;

    logic [31:0]  exp_addr_q[$];
    logic [511:0] exp_line_q[$];
    logic [31:0]  exp_cap_q[$];

    int total = 0;
    int bad   = 0;
    int fills = 0;
    int words = 0;

    logic        prev_rd;
    logic        prev_ack;
    logic [31:0] prev_addr;

    cache_line_filler dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_miss       (miss),
        .i_cpu_addr   (cpu_addr),
        .o_mem_rd     (mem_rd),
        .o_mem_addr   (mem_addr),
        .i_mem_rdata  (mem_rdata),
        .i_mem_ack    (mem_ack),
        .o_cache_read (cache_read),
        .o_cache_addr (cache_addr),
        .o_block_data (block_data),
        .o_busy       (busy),
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
        .o_crit_valid (crit_valid),
        .o_crit_word  (crit_word),
`endif
        .o_dbg_state  (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model
    assign mem_ack = (ack_mode == 2'd0) ? 1'b1 : (ack_mode == 2'd1) ? cyc[0] : 1'b0;
    always_comb mem_rdata = mem_addr ^ salt;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mem_rd"}, 512'(mem_rd), 512'(1'b0));
        check({tag, "_cache_read"}, 512'(cache_read), 512'(1'b1));
        check({tag, "_busy"}, 512'(busy), 512'(1'b0));
        check({tag, "_block_data"}, block_data, 512'd0);
        check({tag, "_mem_addr"}, 512'(mem_addr), 512'd0);
        check({tag, "_state"}, 512'(dbg_state), 512'd0);
    endtask

    // Queue the expected fetch order, the final line and the capture address for a miss at a.
    task automatic expect_fill(input logic [31:0] a);
        logic [3:0]   st;
        logic [511:0] line;
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
        st = a[3:0];
`else
        st = 4'd0;
`endif
        for (int i = 0; i < 16; i++) begin
            exp_addr_q.push_back({a[31:4], 4'(st + i)});
        end
        line = '0;
        for (int k = 0; k < 16; k++) begin
            line[k*32 +: 32] = {a[31:4], 4'(k)} ^ salt;
        end
        exp_line_q.push_back(line);
        exp_cap_q.push_back(a);
    endtask

    // Wait (bounded) for busy to fall. Report after which edge the cache_read pulse and the release occurred.
    task automatic wait_done(output int pulses, output int pulse_k, output int done_k);
        pulses  = 0;
        pulse_k = -1;
        done_k  = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (!cache_read) begin
                pulses++;
                pulse_k = k;
            end
            if (!busy) begin
                done_k = k;
                break;
            end
        end
        if (done_k < 0) begin
            total++;
            bad++;
            $display("FAIL busy_timeout: got busy=1 after 200 cycles want busy=0");
        end
    endtask

    task automatic run_miss(input logic [31:0] a, input logic [1:0] mode,
                            output int pulses, output int pulse_k, output int done_k);
        expect_fill(a);
        ack_mode = mode;
        cpu_addr = a;
        miss     = 1'b1;
        @(posedge clk);
        #1;
        miss = 1'b0;
        check("busy_rise", 512'(busy), 512'(1'b1));
        check("cache_addr_busy", 512'(cache_addr), 512'(a));
        wait_done(pulses, pulse_k, done_k);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_rd && mem_ack) begin
                if (exp_addr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_read: got addr %0h want no read", mem_addr);
                end else begin
                    check("mem_addr", 512'(mem_addr), 512'(exp_addr_q.pop_front()));
                end
                words++;
            end
            if (mem_rd && prev_rd && !prev_ack) begin
                check("addr_hold", 512'(mem_addr), 512'(prev_addr));
            end
            if (!cache_read) begin
                fills++;
                if (exp_line_q.size() == 0 || exp_cap_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_fill: got cache_read=0 want 1");
                end else begin
                    check("block_data", block_data, exp_line_q.pop_front());
                    check("cache_addr_fill", 512'(cache_addr), 512'(exp_cap_q.pop_front()));
                end
            end
        end
        prev_rd   <= mem_rd;
        prev_ack  <= mem_ack;
        prev_addr <= mem_addr;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish before 100000ns");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        int pulses, pulse_k, done_k, w0, f0;
        reset    = 1'b1;
        miss     = 1'b0;
        cpu_addr = 32'd0;
        ack_mode = 2'd2;
        salt     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst");
        reset = 1'b0;

        // Continuous ack: pulse in cycle 17 (after edge 16), idle in cycle 19 (after edge 18).
        run_miss(32'h0001_2345, 2'd0, pulses, pulse_k, done_k);
        check("t1_pulses", 512'(pulses), 512'd1);
        check("t1_pulse_cycle", 512'(pulse_k), 512'd16);
        check("t1_done_cycle", 512'(done_k), 512'd18);
        check("t1_mem_rd_idle", 512'(mem_rd), 512'(1'b0));
        check("t1_cache_addr_idle", 512'(cache_addr), 512'(cpu_addr));

        // Ack only on odd cycles: same line, single pulse, address held in the gaps.
        run_miss(32'h0001_2345, 2'd1, pulses, pulse_k, done_k);
        check("t2_pulses", 512'(pulses), 512'd1);

        // Reset after 5 acks abandons the fill without a write pulse.
        salt = 32'hA5A5_0000;
        w0 = words;
        f0 = fills;
        expect_fill(32'h0000_0777);
        ack_mode = 2'd0;
        cpu_addr = 32'h0000_0777;
        miss     = 1'b1;
        @(posedge clk);
        #1;
        miss = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("abort");
        check("abort_words", 512'(words - w0), 512'd5);
        check("abort_left", 512'(exp_addr_q.size()), 512'd11);
        check("abort_no_fill", 512'(fills - f0), 512'd0);
        exp_addr_q.delete();
        exp_line_q.delete();
        exp_cap_q.delete();
        reset = 1'b0;
        run_miss(32'h0000_0010, 2'd0, pulses, pulse_k, done_k);
        check("t3_pulses", 512'(pulses), 512'd1);
        check("t3_done_cycle", 512'(done_k), 512'd18);

        // Miss held high: one fill per episode, RELEASE blocks retrigger, refill from cycle 19.
        salt = 32'h1111_1111;
        f0 = fills;
        expect_fill(32'h0000_BEEF);
        expect_fill(32'h0000_BEEF);
        ack_mode = 2'd0;
        cpu_addr = 32'h0000_BEEF;
        miss     = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk);
            #1;
            if (k == 8) check("held_busy_c9", 512'(busy), 512'(1'b1));
            if (k == 17) check("held_release", 512'(dbg_state), 512'd3);
            if (k == 18) check("held_idle_gap", 512'(busy), 512'(1'b0));
            if (k == 19) check("held_refill", 512'(busy), 512'(1'b1));
        end
        miss = 1'b0;
        wait_done(pulses, pulse_k, done_k);
        repeat (3) @(posedge clk);
        #1;
        check("held_fills", 512'(fills - f0), 512'd2);
        check("held_no_third", 512'(busy), 512'(1'b0));

        // Miss at 0xAD: critical-word-first order when enabled, offset 0 otherwise.
        salt = 32'd0;
        expect_fill(32'h0000_00AD);
        ack_mode = 2'd0;
        cpu_addr = 32'h0000_00AD;
        miss     = 1'b1;
        @(posedge clk);
        #1;
        miss = 1'b0;
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
        check("crit_valid_c1", 512'(crit_valid), 512'(1'b1));
        check("crit_word_c1", 512'(crit_word), 512'h0000_00AD);
        @(posedge clk);
        #1;
        check("crit_valid_c2", 512'(crit_valid), 512'(1'b0));
        check("crit_word_hold", 512'(crit_word), 512'h0000_00AD);
`endif
        wait_done(pulses, pulse_k, done_k);
        check("t5_pulses", 512'(pulses), 512'd1);
        check("t5_slot13", 512'(block_data[13*32 +: 32]), 512'h0000_00AD);
        check("t5_slot0", 512'(block_data[31:0]), 512'h0000_00A0);

        check("q_addr_empty", 512'(exp_addr_q.size()), 512'd0);
        check("q_line_empty", 512'(exp_line_q.size()), 512'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
